baser_257b_multilane_checker: RTL

Parametrised successor to the single-lane 257b checker.
- Classifies N_LANES 256b/257b transcoded words per clock as all-data, control or invalid.
- Keeps saturating, clearable aggregate counters.
- Runs a windowed error-density monitor that raises a high-error flag.
- Sits on the RX side after transcode alignment and before the 257b→64b/66b decoder; used as a verification/monitor agent.

---
 rtl/baser_257b_multilane_checker.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/baser_257b_multilane_checker.sv
// Classifies N_LANES 257b transcoded words per cycle as data, control or invalid;
// keeps saturating aggregate counters and a windowed error-density monitor.
module baser_257b_multilane_checker #(
   parameter int unsigned N_LANES       = 4,
   parameter int unsigned CNT_WIDTH     = 32,
   parameter int unsigned WINDOW_CYCLES = 1024,
   parameter int unsigned ERR_THRESH    = 97
) (
   input  logic                     clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   input  logic [N_LANES*257-1:0]   i_rx_coded,
   input  logic                     i_clr_cnt,
   output logic [CNT_WIDTH-1:0]     o_block_count,
   output logic [CNT_WIDTH-1:0]     o_data_count,
   output logic [CNT_WIDTH-1:0]     o_ctrl_count,
   output logic [CNT_WIDTH-1:0]     o_inv_block_count,
   output logic [N_LANES-1:0]       o_lane_inv,
   output logic                     o_hi_err
);

   localparam int unsigned WORD_W  = 257;
   localparam int unsigned LANE_CW = $clog2(N_LANES + 1);
   localparam int unsigned SUM_W   = CNT_WIDTH + LANE_CW;
   localparam int unsigned WIN_W   = $clog2(WINDOW_CYCLES);
   localparam int unsigned ERR_W   = $clog2(ERR_THRESH + 1);
   localparam int unsigned ESUM_W  = ERR_W + LANE_CW;

   typedef enum logic {MONITOR = 1'b0, HI_ERR = 1'b1} state_t;

   function automatic logic ctrl_type_ok(input logic [7:0] t);
      logic ok;
      case (t)
         8'h1E, 8'h2D, 8'h33, 8'h4B, 8'h55, 8'h66, 8'h78, 8'h87,
         8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF: ok = 1'b1;
         default:                                          ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Walks the four blocks; the first control block is 4 bits shorter than the rest.
   function automatic logic word_inv(input logic [WORD_W-1:0] w);
      logic [3:0] flags;
      logic [8:0] pos;
      logic       seen_ctrl;
      logic       bad;
      flags     = w[4:1];
      pos       = 9'd5;
      seen_ctrl = 1'b0;
      bad       = (flags == 4'hF);
      for (int unsigned k = 0; k < 4; k++) begin
         if (flags[2'(k)]) begin
            pos = pos + 9'd64;
         end else if (!seen_ctrl) begin
            bad       = bad | (w[pos +: 4] == 4'h0);
            seen_ctrl = 1'b1;
            pos       = pos + 9'd60;
         end else begin
            bad = bad | !ctrl_type_ok(w[pos +: 8]);
            pos = pos + 9'd64;
         end
      end
      return bad & ~w[0];
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                    input logic [LANE_CW-1:0]   inc);
      logic [SUM_W-1:0] s;
      s = SUM_W'(c) + SUM_W'(inc);
      return (s[SUM_W-1:CNT_WIDTH] != '0) ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
   endfunction

   logic [N_LANES-1:0]   lane_inv_c;
   logic [N_LANES-1:0]   lane_data_c;
   logic [N_LANES-1:0]   lane_ctrl_c;
   logic [LANE_CW-1:0]   n_data_c;
   logic [LANE_CW-1:0]   n_ctrl_c;
   logic [LANE_CW-1:0]   n_inv_c;

   for (genvar g = 0; g < N_LANES; g++) begin : g_lane
      logic [WORD_W-1:0] word;
      assign word           = i_rx_coded[g*WORD_W +: WORD_W];
      assign lane_inv_c[g]  = word_inv(word);
      assign lane_data_c[g] = word[0];
   end

   assign lane_ctrl_c = ~lane_data_c & ~lane_inv_c;
   assign n_data_c    = LANE_CW'($countones(lane_data_c));
   assign n_ctrl_c    = LANE_CW'($countones(lane_ctrl_c));
   assign n_inv_c     = LANE_CW'($countones(lane_inv_c));

   logic [CNT_WIDTH-1:0] block_q, data_q, ctrl_q, inv_q;
   logic [N_LANES-1:0]   lane_inv_q;

   // Aggregate counters; clear wins over counting.
   always_ff @(posedge clk) begin
      if (i_rst || i_clr_cnt) begin
         block_q <= '0;
         data_q  <= '0;
         ctrl_q  <= '0;
         inv_q   <= '0;
      end else if (i_valid) begin
         block_q <= sat_add(block_q, LANE_CW'(N_LANES));
         data_q  <= sat_add(data_q, n_data_c);
         ctrl_q  <= sat_add(ctrl_q, n_ctrl_c);
         inv_q   <= sat_add(inv_q, n_inv_c);
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         lane_inv_q <= '0;
      end else if (i_valid) begin
         lane_inv_q <= lane_inv_c;
      end
   end

   logic [WIN_W-1:0]  win_cnt_q;
   logic [ERR_W-1:0]  err_cnt_q;
   logic [ESUM_W-1:0] err_sum_c;
   logic [ERR_W-1:0]  err_next_c;
   logic              hit_c;
   logic              win_last_c;
   state_t            state_q, state_d;
   logic              hi_err_q;

   assign err_sum_c  = ESUM_W'(err_cnt_q) + ESUM_W'(n_inv_c);
   assign hit_c      = (err_sum_c >= ESUM_W'(ERR_THRESH));
   assign err_next_c = hit_c ? ERR_W'(ERR_THRESH) : err_sum_c[ERR_W-1:0];
   assign win_last_c = (win_cnt_q == WIN_W'(WINDOW_CYCLES - 1));

   // Window position and clamped error count.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         win_cnt_q <= '0;
         err_cnt_q <= '0;
      end else if (i_valid) begin
         if (win_last_c) begin
            win_cnt_q <= '0;
            err_cnt_q <= '0;
         end else begin
            win_cnt_q <= win_cnt_q + WIN_W'(1);
            err_cnt_q <= err_next_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q  <= MONITOR;
         hi_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         hi_err_q <= (state_d == HI_ERR);
      end
   end

   // Threshold hit takes priority over the end-of-window return to MONITOR.
   always_comb begin
      state_d = state_q;
      if (i_valid) begin
         if (hit_c) begin
            state_d = HI_ERR;
         end else if (win_last_c) begin
            state_d = MONITOR;
         end
      end
   end

   assign o_block_count     = block_q;
   assign o_data_count      = data_q;
   assign o_ctrl_count      = ctrl_q;
   assign o_inv_block_count = inv_q;
   assign o_lane_inv        = lane_inv_q;
   assign o_hi_err          = hi_err_q;

endmodule
